explosion_anim: RTL and testbench

Consumer side of the per-enemy explosion flags: detects rising edges on the 19 explosion request lines (12 basic, 4 shooter, 3 fast enemies), queues them, and assigns each to one of a small pool of animation slots. Each slot latches the exploding enemy's position and steps through a fixed sprite sequence on frame_clk. The color mapper draws from the per-slot outputs, and game control uses the per-slot done pulse to respawn or clear the enemy.

---
 rtl/explosion_anim.sv | 190 +++++++++++++++++++
 tb/tb_explosion_anim.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/explosion_anim.sv
`default_nettype none
// ============================================================================
// Module   : explosion_anim
// Purpose  : Edge-detects explosion requests and plays them on a slot pool.
// Revision : 1.0
// ============================================================================
module explosion_anim #(
    parameter int NUM_SRC         = 19,
    parameter int NUM_SLOTS       = 4,
    parameter int FRAMES_PER_STEP = 4,
    parameter int NUM_STEPS       = 4
) (
    input  logic                                frame_clk,
    input  logic                                Reset,
    input  logic [NUM_SRC-1:0]                  exp_vec,
    input  logic [10*NUM_SRC-1:0]               src_x,
    input  logic [10*NUM_SRC-1:0]               src_y,
    output logic [NUM_SLOTS-1:0]                slot_active,
    output logic [10*NUM_SLOTS-1:0]             slot_x,
    output logic [10*NUM_SLOTS-1:0]             slot_y,
    output logic [$clog2(NUM_STEPS)*NUM_SLOTS-1:0] slot_step,
    output logic [5*NUM_SLOTS-1:0]              slot_src,
    output logic [NUM_SLOTS-1:0]                slot_done,
    output logic [NUM_SRC-1:0]                  ack_vec,
    output logic                                busy
);

    localparam int SW  = $clog2(NUM_STEPS);
    localparam int TW  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int SLW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    localparam logic [0:0]    S_IDLE      = 1'b0;
    localparam logic [0:0]    S_PLAY      = 1'b1;
    localparam logic [TW-1:0] C_TICK_LAST = TW'(FRAMES_PER_STEP - 1);
    localparam logic [SW-1:0] C_STEP_LAST = SW'(NUM_STEPS - 1);

    logic [NUM_SRC-1:0] exp_prev_q, exp_prev_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] ack_q, ack_d;
    logic [NUM_SRC-1:0] rise;

    logic [0:0]    state_q [NUM_SLOTS];
    logic [0:0]    state_d [NUM_SLOTS];
    logic [TW-1:0] tick_q  [NUM_SLOTS];
    logic [TW-1:0] tick_d  [NUM_SLOTS];
    logic [SW-1:0] step_q  [NUM_SLOTS];
    logic [SW-1:0] step_d  [NUM_SLOTS];
    logic [9:0]    x_q     [NUM_SLOTS];
    logic [9:0]    x_d     [NUM_SLOTS];
    logic [9:0]    y_q     [NUM_SLOTS];
    logic [9:0]    y_d     [NUM_SLOTS];
    logic [4:0]    src_q   [NUM_SLOTS];
    logic [4:0]    src_d   [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] done_q, done_d;

    logic [9:0] sx [NUM_SRC];
    logic [9:0] sy [NUM_SRC];

    logic           alloc_valid;
    logic           src_found;
    logic           slot_found;
    logic [4:0]     alloc_src;
    logic [SLW-1:0] alloc_slot;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            assign sx[i] = src_x[10*i +: 10];
            assign sy[i] = src_y[10*i +: 10];
        end
    endgenerate

    // State register
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            exp_prev_q <= '0;
            pending_q  <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state_q[s] <= S_IDLE;
                tick_q[s]  <= '0;
                step_q[s]  <= '0;
                x_q[s]     <= '0;
                y_q[s]     <= '0;
                src_q[s]   <= '0;
            end
        end else begin
            exp_prev_q <= exp_prev_d;
            pending_q  <= pending_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state_q[s] <= state_d[s];
                tick_q[s]  <= tick_d[s];
                step_q[s]  <= step_d[s];
                x_q[s]     <= x_d[s];
                y_q[s]     <= y_d[s];
                src_q[s]   <= src_d[s];
            end
        end
    end

    // Allocator: lowest pending source to lowest idle slot, from registered state only
    always_comb begin
        src_found  = 1'b0;
        slot_found = 1'b0;
        alloc_src  = '0;
        alloc_slot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!src_found && pending_q[i]) begin
                src_found = 1'b1;
                alloc_src = 5'(i);
            end
        end
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (!slot_found && state_q[s] == S_IDLE) begin
                slot_found = 1'b1;
                alloc_slot = SLW'(s);
            end
        end
        alloc_valid = src_found & slot_found;
    end

    // Next-state logic
    always_comb begin
        rise       = exp_vec & ~exp_prev_q;
        exp_prev_d = exp_vec;
        pending_d  = pending_q;
        ack_d      = '0;
        done_d     = '0;
        if (alloc_valid) begin
            pending_d[alloc_src] = 1'b0;
            ack_d[alloc_src]     = 1'b1;
        end
        // A rise on the same edge as allocation re-arms the request
        pending_d = pending_d | rise;

        for (int s = 0; s < NUM_SLOTS; s++) begin
            state_d[s] = state_q[s];
            tick_d[s]  = tick_q[s];
            step_d[s]  = step_q[s];
            x_d[s]     = x_q[s];
            y_d[s]     = y_q[s];
            src_d[s]   = src_q[s];
            case (state_q[s])
                S_IDLE: begin
                    if (alloc_valid && alloc_slot == SLW'(s)) begin
                        state_d[s] = S_PLAY;
                        tick_d[s]  = '0;
                        step_d[s]  = '0;
                        x_d[s]     = sx[alloc_src];
                        y_d[s]     = sy[alloc_src];
                        src_d[s]   = alloc_src;
                    end
                end
                S_PLAY: begin
                    if (tick_q[s] == C_TICK_LAST) begin
                        tick_d[s] = '0;
                        if (step_q[s] == C_STEP_LAST) begin
                            state_d[s] = S_IDLE;
                            done_d[s]  = 1'b1;
                        end else begin
                            step_d[s] = step_q[s] + 1'b1;
                        end
                    end else begin
                        tick_d[s] = tick_q[s] + 1'b1;
                    end
                end
                default: state_d[s] = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
            slot_active[s]         = (state_q[s] == S_PLAY);
            slot_x[10*s +: 10]     = x_q[s];
            slot_y[10*s +: 10]     = y_q[s];
            slot_step[SW*s +: SW]  = step_q[s];
            slot_src[5*s +: 5]     = src_q[s];
        end
    end

    assign slot_done = done_q;
    assign ack_vec   = ack_q;
    assign busy      = (|pending_q) | (|slot_active);

endmodule
`default_nettype wire

// File: tb/tb_explosion_anim.sv
`default_nettype none
// ============================================================================
// Module   : tb_explosion_anim
// Purpose  : Directed scoreboard bench for explosion_anim.
// Revision : 1.0
// ============================================================================
module tb_explosion_anim;

    localparam int NSRC  = 19;
    localparam int NSLOT = 4;

    logic              frame_clk;
    logic              Reset;
    logic [NSRC-1:0]   exp_vec;
    logic [10*NSRC-1:0] src_x;
    logic [10*NSRC-1:0] src_y;
    logic [NSLOT-1:0]  slot_active;
    logic [10*NSLOT-1:0] slot_x;
    logic [10*NSLOT-1:0] slot_y;
    logic [2*NSLOT-1:0]  slot_step;
    logic [5*NSLOT-1:0]  slot_src;
    logic [NSLOT-1:0]  slot_done;
    logic [NSRC-1:0]   ack_vec;
    logic              busy;

    explosion_anim dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .exp_vec     (exp_vec),
        .src_x       (src_x),
        .src_y       (src_y),
        .slot_active (slot_active),
        .slot_x      (slot_x),
        .slot_y      (slot_y),
        .slot_step   (slot_step),
        .slot_src    (slot_src),
        .slot_done   (slot_done),
        .ack_vec     (ack_vec),
        .busy        (busy)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int         src;
        int         slot;
        logic [9:0] x;
        logic [9:0] y;
    } alloc_t;

    alloc_t sb[$];
    int     tests = 0;
    int     fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    task automatic set_pos(input int i, input logic [9:0] x, input logic [9:0] y);
        src_x[10*i +: 10] = x;
        src_y[10*i +: 10] = y;
    endtask

    function automatic logic [9:0] px(input int i);
        return src_x[10*i +: 10];
    endfunction

    function automatic logic [9:0] py(input int i);
        return src_y[10*i +: 10];
    endfunction

    task automatic expect_alloc(input int src, input int slot);
        alloc_t a;
        a.src  = src;
        a.slot = slot;
        a.x    = px(src);
        a.y    = py(src);
        sb.push_back(a);
    endtask

    // Scoreboard monitor: every ack must match the next expected allocation
    always @(negedge frame_clk) begin
        if (!Reset && ack_vec !== '0) begin
            if (sb.size() == 0) begin
                chk("ack_unexpected", 64'(ack_vec), 64'd0);
            end else begin
                alloc_t a;
                logic [NSRC-1:0] one;
                a = sb.pop_front();
                one = '0;
                one[a.src] = 1'b1;
                chk("ack_vec", 64'(ack_vec), 64'(one));
                chk("alloc_active", 64'(slot_active[a.slot]), 64'd1);
                chk("alloc_src", 64'(slot_src[5*a.slot +: 5]), 64'(a.src));
                chk("alloc_x", 64'(slot_x[10*a.slot +: 10]), 64'(a.x));
                chk("alloc_y", 64'(slot_y[10*a.slot +: 10]), 64'(a.y));
                chk("alloc_step", 64'(slot_step[2*a.slot +: 2]), 64'd0);
            end
        end
    end

    initial begin
        Reset   = 1'b1;
        exp_vec = '0;
        for (int i = 0; i < NSRC; i++) set_pos(i, 10'(10*i + 7), 10'(3*i + 20));
        set_pos(3, 10'd100, 10'd50);

        #3;
        chk("rst_active", 64'(slot_active), 64'd0);
        chk("rst_ack", 64'(ack_vec), 64'd0);
        chk("rst_done", 64'(slot_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_x", 64'(slot_x), 64'd0);
        #9 Reset = 1'b0;
        cyc(2);

        // Single request on source 3
        exp_vec[3] = 1'b1;
        expect_alloc(3, 0);
        cyc(1);
        chk("single_pending_busy", 64'(busy), 64'd1);
        chk("single_not_yet", 64'(slot_active), 64'd0);
        exp_vec[3] = 1'b0;
        cyc(1);
        for (int j = 0; j < 16; j++) begin
            chk("single_active", 64'(slot_active), 64'd1);
            chk("single_step", 64'(slot_step[1:0]), 64'(j / 4));
            chk("single_done_low", 64'(slot_done), 64'd0);
            if (j == 5) set_pos(3, 10'd300, 10'd50);
            cyc(1);
        end
        chk("single_end_active", 64'(slot_active), 64'd0);
        chk("single_done_pulse", 64'(slot_done), 64'd1);
        chk("pos_latched", 64'(slot_x[9:0]), 64'd100);
        cyc(1);
        chk("single_done_clear", 64'(slot_done), 64'd0);
        chk("single_idle_busy", 64'(busy), 64'd0);

        // Simultaneous burst: 0,5,12,16 fill slots, 18 waits for slot 0
        exp_vec[0] = 1'b1; exp_vec[5] = 1'b1; exp_vec[12] = 1'b1;
        exp_vec[16] = 1'b1; exp_vec[18] = 1'b1;
        expect_alloc(0, 0);
        expect_alloc(5, 1);
        expect_alloc(12, 2);
        expect_alloc(16, 3);
        expect_alloc(18, 0);
        cyc(1);
        exp_vec = '0;
        cyc(4);
        chk("burst_full", 64'(slot_active), 64'hF);
        chk("burst_slot3_src", 64'(slot_src[19:15]), 64'd16);
        cyc(12);
        chk("burst_s0_still", 64'(slot_active[0]), 64'd1);
        chk("burst_18_waiting", 64'(busy), 64'd1);
        cyc(1);
        chk("burst_s0_done", 64'(slot_done[0]), 64'd1);
        chk("burst_s0_idle", 64'(slot_active[0]), 64'd0);
        cyc(1);
        chk("burst_18_alloc", 64'(slot_src[4:0]), 64'd18);
        chk("burst_18_active", 64'(slot_active[0]), 64'd1);
        cyc(20);
        chk("burst_drained", 64'(busy), 64'd0);

        // Held level: one allocation only
        exp_vec[7] = 1'b1;
        expect_alloc(7, 0);
        cyc(40);
        exp_vec[7] = 1'b0;
        cyc(2);
        chk("held_busy_done", 64'(busy), 64'd0);

        // Re-rise while pending with all slots busy
        exp_vec[8] = 1'b1; exp_vec[9] = 1'b1; exp_vec[10] = 1'b1; exp_vec[11] = 1'b1;
        expect_alloc(8, 0);
        expect_alloc(9, 1);
        expect_alloc(10, 2);
        expect_alloc(11, 3);
        expect_alloc(2, 0);
        cyc(1);
        exp_vec = '0;
        cyc(4);
        exp_vec[2] = 1'b1; cyc(1);
        exp_vec[2] = 1'b0; cyc(2);
        exp_vec[2] = 1'b1; cyc(1);
        exp_vec[2] = 1'b0; cyc(1);
        chk("rerise_full", 64'(slot_active), 64'hF);
        cyc(8);
        chk("rerise_s0_idle", 64'(slot_active[0]), 64'd0);
        cyc(1);
        chk("rerise_alloc", 64'(slot_src[4:0]), 64'd2);
        cyc(20);
        chk("rerise_drained", 64'(busy), 64'd0);

        // Async reset mid-animation with 4 and 5 still pending
        exp_vec[5:0] = 6'h3F;
        expect_alloc(0, 0);
        expect_alloc(1, 1);
        expect_alloc(2, 2);
        expect_alloc(3, 3);
        cyc(6);
        #2 Reset = 1'b1;
        #1;
        chk("areset_active", 64'(slot_active), 64'd0);
        chk("areset_busy", 64'(busy), 64'd0);
        chk("areset_done", 64'(slot_done), 64'd0);
        chk("areset_ack", 64'(ack_vec), 64'd0);
        chk("areset_xy", 64'({slot_x, slot_y}), 64'd0);
        chk("areset_step", 64'(slot_step), 64'd0);
        exp_vec = '0;
        exp_vec[4] = 1'b1;
        cyc(2);
        chk("areset_hold_done", 64'(slot_done), 64'd0);
        #2 Reset = 1'b0;
        expect_alloc(4, 0);
        cyc(1);
        chk("rerequest_pending", 64'(busy), 64'd1);
        chk("rerequest_no_slot", 64'(slot_active), 64'd0);
        cyc(1);
        chk("rerequest_active", 64'(slot_active), 64'd1);
        exp_vec = '0;
        cyc(20);
        chk("final_idle", 64'(busy), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
